// File: rtl/timer_ctrl.sv
// timer_ctrl - mode and count controller for the Basys3 digital timer.
//
// Owns the seconds/minutes registers and sequences set, run and pause from
// debounced one-cycle button pulses and a 1 Hz tick. Every output is a
// register so the digit splitter and blink logic see clean values.
//
// Build option:
//   TIMER_COUNTDOWN_EN  defined     : RUN counts down and stops in DONE at 00:00
//   TIMER_COUNTDOWN_EN  not defined : RUN counts up (stopwatch), done tied to 0
//
// Button priority in every cycle is start > mode > inc; a lower-priority
// pulse arriving together with a higher one is dropped, even in states where
// the higher one has no effect.

module timer_ctrl #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic       running,
    output logic [1:0] set_sel,
    output logic       done
);

    localparam logic [5:0] MAX_MIN_C = 6'(MAX_MIN);
    localparam logic [5:0] MAX_SEC_C = 6'd59;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_SEC  = 2'b10;

`ifdef TIMER_COUNTDOWN_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;
`endif

    // Increment with wrap: anything at or above the limit folds back to 0,
    // so a corrupted register can never walk out of range.
    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
        logic [5:0] r;
        if (v >= lim) begin
            r = 6'd0;
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

    // Decrement with wrap: 0 goes to the limit, out-of-range values clamp to it.
    function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] lim);
        logic [5:0] r;
        if (v == 6'd0) begin
            r = lim;
        end else if (v > lim) begin
            r = lim;
        end else begin
            r = v - 6'd1;
        end
        return r;
    endfunction

    state_t     state_r;
    state_t     state_nx_s;
    logic [5:0] sec_r;
    logic [5:0] min_r;
    logic [5:0] sec_nx_s;
    logic [5:0] min_nx_s;
    logic       running_r;
    logic       running_nx_s;
    logic [1:0] set_sel_r;
    logic [1:0] set_sel_nx_s;

    // Tick-driven count candidate, derived from the current value in every state.
    logic [5:0] cnt_sec_s;
    logic [5:0] cnt_min_s;

    // Prioritised button pulses.
    logic       start_s;
    logic       mode_s;
    logic       inc_s;

    assign start_s = btn_start;
    assign mode_s  = btn_mode & ~btn_start;
    assign inc_s   = btn_inc & ~btn_start & ~btn_mode;

`ifdef TIMER_COUNTDOWN_EN
    logic       done_r;
    logic       done_nx_s;
    logic       cnt_zero_s;
    logic       can_start_s;

    assign cnt_zero_s  = (cnt_sec_s == 6'd0) && (cnt_min_s == 6'd0);
    assign can_start_s = (sec_r != 6'd0) || (min_r != 6'd0);

    // Countdown step: seconds borrow from minutes when they pass zero.
    always_comb begin
        cnt_sec_s = sec_r;
        cnt_min_s = min_r;
        if (sec_r == 6'd0) begin
            cnt_sec_s = MAX_SEC_C;
            cnt_min_s = dec_wrap(min_r, MAX_MIN_C);
        end else begin
            cnt_sec_s = dec_wrap(sec_r, MAX_SEC_C);
            cnt_min_s = min_r;
        end
    end
`else
    // Up-count step: seconds carry into minutes, minutes wrap past MAX_MIN.
    always_comb begin
        cnt_sec_s = sec_r;
        cnt_min_s = min_r;
        if (sec_r >= MAX_SEC_C) begin
            cnt_sec_s = 6'd0;
            cnt_min_s = inc_wrap(min_r, MAX_MIN_C);
        end else begin
            cnt_sec_s = sec_r + 6'd1;
            cnt_min_s = min_r;
        end
    end
`endif

    // Next-state and next-value logic for the mode FSM and count registers.
    always_comb begin
        state_nx_s = state_r;
        sec_nx_s   = sec_r;
        min_nx_s   = min_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
`ifdef TIMER_COUNTDOWN_EN
                    if (can_start_s) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
`else
                    state_nx_s = ST_RUN;
`endif
                end else if (mode_s) begin
                    state_nx_s = ST_SET_MIN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SET_MIN: begin
                if (mode_s) begin
                    state_nx_s = ST_SET_SEC;
                end else if (inc_s) begin
                    min_nx_s = inc_wrap(min_r, MAX_MIN_C);
                end else begin
                    state_nx_s = ST_SET_MIN;
                end
            end
            ST_SET_SEC: begin
                if (mode_s) begin
                    state_nx_s = ST_IDLE;
                end else if (inc_s) begin
                    sec_nx_s = inc_wrap(sec_r, MAX_SEC_C);
                end else begin
                    state_nx_s = ST_SET_SEC;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    sec_nx_s = cnt_sec_s;
                    min_nx_s = cnt_min_s;
                end else begin
                    sec_nx_s = sec_r;
                    min_nx_s = min_r;
                end
`ifdef TIMER_COUNTDOWN_EN
                // Reaching zero wins over a simultaneous pause request.
                if (tick && cnt_zero_s) begin
                    state_nx_s = ST_DONE;
                end else if (start_s) begin
                    state_nx_s = ST_PAUSE;
                end else begin
                    state_nx_s = ST_RUN;
                end
`else
                if (start_s) begin
                    state_nx_s = ST_PAUSE;
                end else begin
                    state_nx_s = ST_RUN;
                end
`endif
            end
            ST_PAUSE: begin
                if (start_s) begin
                    state_nx_s = ST_RUN;
                end else if (mode_s) begin
                    state_nx_s = ST_IDLE;
                    sec_nx_s   = 6'd0;
                    min_nx_s   = 6'd0;
                end else begin
                    state_nx_s = ST_PAUSE;
                end
            end
`ifdef TIMER_COUNTDOWN_EN
            ST_DONE: begin
                sec_nx_s = 6'd0;
                min_nx_s = 6'd0;
                if (start_s || mode_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
`endif
            default: begin
                state_nx_s = ST_IDLE;
                sec_nx_s   = 6'd0;
                min_nx_s   = 6'd0;
            end
        endcase
    end

    // Status outputs decoded from the next state so they change with it.
    always_comb begin
        running_nx_s = 1'b0;
        set_sel_nx_s = SEL_NONE;
        case (state_nx_s)
            ST_RUN:     running_nx_s = 1'b1;
            ST_SET_MIN: set_sel_nx_s = SEL_MIN;
            ST_SET_SEC: set_sel_nx_s = SEL_SEC;
            default: begin
                running_nx_s = 1'b0;
                set_sel_nx_s = SEL_NONE;
            end
        endcase
    end

`ifdef TIMER_COUNTDOWN_EN
    assign done_nx_s = (state_nx_s == ST_DONE);
`endif

    // State, count and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            sec_r     <= 6'd0;
            min_r     <= 6'd0;
            running_r <= 1'b0;
            set_sel_r <= SEL_NONE;
`ifdef TIMER_COUNTDOWN_EN
            done_r    <= 1'b0;
`endif
        end else begin
            state_r   <= state_nx_s;
            sec_r     <= sec_nx_s;
            min_r     <= min_nx_s;
            running_r <= running_nx_s;
            set_sel_r <= set_sel_nx_s;
`ifdef TIMER_COUNTDOWN_EN
            done_r    <= done_nx_s;
`endif
        end
    end

    assign seconds = sec_r;
    assign minutes = min_r;
    assign running = running_r;
    assign set_sel = set_sel_r;
`ifdef TIMER_COUNTDOWN_EN
    assign done    = done_r;
`else
    assign done    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl - self-checking bench for timer_ctrl.
// The reference model tracks the displayed value as a single count of seconds
// and the mode as a small integer; every cycle all outputs are compared.

module tb_timer_ctrl;

    localparam int MAXM   = 59;
    localparam int PERIOD = (MAXM + 1) * 60;
`ifdef TIMER_COUNTDOWN_EN
    localparam bit CD = 1'b1;
`else
    localparam bit CD = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_SETMIN = 1;
    localparam int M_SETSEC = 2;
    localparam int M_RUN    = 3;
    localparam int M_PAUSE  = 4;
    localparam int M_DONE   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       btn_start;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       running;
    logic [1:0] set_sel;
    logic       done;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int m_mode    = M_IDLE;
    int m_time    = 0;

    timer_ctrl #(.MAX_MIN(MAXM)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_start (btn_start),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .seconds   (seconds),
        .minutes   (minutes),
        .running   (running),
        .set_sel   (set_sel),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input int exp);
        total_cnt++;
        if (act !== 32'(exp)) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge with the given inputs.
    task automatic model_step(input bit r, input bit tk, input bit bs, input bit bm, input bit bi);
        bit ps, pm, pi;
        int mm, ss;
        if (r) begin
            m_mode = M_IDLE;
            m_time = 0;
        end else begin
            ps = bs;
            pm = bm && !bs;
            pi = bi && !bs && !bm;
            mm = m_time / 60;
            ss = m_time % 60;
            case (m_mode)
                M_IDLE: begin
                    if (ps) begin
                        if (!(CD && m_time == 0)) m_mode = M_RUN;
                    end else if (pm) begin
                        m_mode = M_SETMIN;
                    end
                end
                M_SETMIN: begin
                    if (pm) m_mode = M_SETSEC;
                    else if (pi) m_time = ((mm == MAXM) ? 0 : mm + 1) * 60 + ss;
                end
                M_SETSEC: begin
                    if (pm) m_mode = M_IDLE;
                    else if (pi) m_time = mm * 60 + ((ss == 59) ? 0 : ss + 1);
                end
                M_RUN: begin
                    if (tk) begin
                        if (CD) m_time = m_time - 1;
                        else m_time = (m_time + 1) % PERIOD;
                    end
                    if (CD && tk && m_time == 0) m_mode = M_DONE;
                    else if (ps) m_mode = M_PAUSE;
                end
                M_PAUSE: begin
                    if (ps) m_mode = M_RUN;
                    else if (pm) begin
                        m_mode = M_IDLE;
                        m_time = 0;
                    end
                end
                M_DONE: begin
                    if (ps || pm) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // One clock cycle: drive on the falling edge, compare #1 after the rising edge.
    task automatic cyc(input bit r, input bit tk, input bit bs, input bit bm, input bit bi);
        int exp_sel;
        @(negedge clk);
        reset     = r;
        tick      = tk;
        btn_start = bs;
        btn_mode  = bm;
        btn_inc   = bi;
        @(posedge clk);
        model_step(r, tk, bs, bm, bi);
        #1;
        exp_sel = (m_mode == M_SETMIN) ? 1 : ((m_mode == M_SETSEC) ? 2 : 0);
        check_val("seconds", 32'(seconds), m_time % 60);
        check_val("minutes", 32'(minutes), m_time / 60);
        check_val("running", 32'(running), (m_mode == M_RUN) ? 1 : 0);
        check_val("set_sel", 32'(set_sel), exp_sel);
        check_val("done",    32'(done),    (m_mode == M_DONE) ? 1 : 0);
    endtask

    task automatic do_reset();  cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_tick();   cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_start();  cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic do_mode();   cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic do_inc(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reset, then load mm:ss through the set flow, ending in IDLE.
    task automatic set_value(input int mm, input int ss);
        do_reset();
        do_mode();
        do_inc(mm);
        do_mode();
        do_inc(ss);
        do_mode();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; btn_start = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;

        // Reset state
        do_reset();
        do_reset();
        check_val("rst_sec", 32'(seconds), 0);
        check_val("rst_min", 32'(minutes), 0);
        check_val("rst_run", 32'(running), 0);
        check_val("rst_sel", 32'(set_sel), 0);
        check_val("rst_done", 32'(done), 0);

        // Set flow with set_sel sequence
        do_mode();
        check_val("sel_min", 32'(set_sel), 1);
        do_inc(2);
        do_mode();
        check_val("sel_sec", 32'(set_sel), 2);
        do_inc(5);
        do_mode();
        check_val("sel_none", 32'(set_sel), 0);
        check_val("set_min", 32'(minutes), 2);
        check_val("set_sec", 32'(seconds), 5);
        do_mode();
        do_mode();
        do_inc(60);
        check_val("sec_wrap60", 32'(seconds), 5);
        do_mode();

        // Minutes wrap in SET_MIN
        set_value(MAXM, 0);
        do_mode();
        do_inc(1);
        check_val("min_setwrap", 32'(minutes), 0);

        // Reset mid-RUN at 03:17 with tick present
        set_value(3, 17);
        do_start();
        do_tick();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rstrun_sec", 32'(seconds), 0);
        check_val("rstrun_min", 32'(minutes), 0);
        check_val("rstrun_run", 32'(running), 0);
        check_val("rstrun_sel", 32'(set_sel), 0);

        // Pause and clear
        set_value(0, 10);
        do_start();
        do_start();
        check_val("pause_run", 32'(running), 0);
        for (int k = 0; k < 3; k++) do_tick();
        check_val("pause_sec", 32'(seconds), 10);
        do_mode();
        check_val("clear_sec", 32'(seconds), 0);
        check_val("clear_min", 32'(minutes), 0);

        // Simultaneous buttons in IDLE (from 00:10 so countdown builds start too)
        set_value(0, 10);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("simul_run", 32'(running), 1);
        check_val("simul_sel", 32'(set_sel), 0);
        check_val("simul_min", 32'(minutes), 0);

`ifdef TIMER_COUNTDOWN_EN
        set_value(1, 1);
        do_start();
        do_tick();
        check_val("cd_1", 32'(minutes * 6'd60 + seconds), 60);
        do_tick();
        check_val("cd_2", 32'(minutes * 6'd60 + seconds), 59);
        set_value(0, 1);
        do_start();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("cd_zero", 32'(seconds), 0);
        check_val("cd_done", 32'(done), 1);
        check_val("cd_notrun", 32'(running), 0);
        do_start();
        check_val("cd_clr", 32'(done), 0);
        do_start();
        check_val("cd_nostart", 32'(running), 0);
`else
        set_value(0, 58);
        do_start();
        do_tick();
        check_val("up_1", 32'(minutes * 6'd60 + seconds), 59);
        do_tick();
        check_val("up_2", 32'(minutes * 6'd60 + seconds), 60);
        do_tick();
        check_val("up_3", 32'(minutes * 6'd60 + seconds), 61);
        set_value(MAXM, 59);
        do_start();
        do_tick();
        check_val("wrap_sec", 32'(seconds), 0);
        check_val("wrap_min", 32'(minutes), 0);
        check_val("wrap_run", 32'(running), 1);
        set_value(0, 5);
        do_start();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("tp_sec", 32'(seconds), 6);
        check_val("tp_run", 32'(running), 0);
        check_val("done_tied", 32'(done), 0);
`endif

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
